// File: rtl/edge_event_detector_pkg.sv
// Shared types for the multi-channel edge event detector.
// Holds the mode codes and the per-channel FSM state encoding.
package edge_event_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_UNINIT = 2'd0,
        ST_LOW    = 2'd1,
        ST_HIGH   = 2'd2
    } ch_state_e;

endpackage

// File: rtl/edge_event_detector_if.sv
// Bundle of the edge detector's channel inputs and event outputs.
// master: ain/mode/clear/irq_en out, pulse/sticky/count/irq in; slave mirrors.
interface edge_event_detector_if #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8
);

    logic [CHANNELS-1:0]           ain;
    logic [2*CHANNELS-1:0]         mode;
    logic [CHANNELS-1:0]           clear;
    logic [CHANNELS-1:0]           irq_en;
    logic [CHANNELS-1:0]           pulse;
    logic [CHANNELS-1:0]           sticky;
    logic [CHANNELS*CNT_WIDTH-1:0] count;
    logic                          irq;

    modport master (
        output ain, mode, clear, irq_en,
        input  pulse, sticky, count, irq
    );

    modport slave (
        input  ain, mode, clear, irq_en,
        output pulse, sticky, count, irq
    );

endinterface

// File: rtl/edge_event_detector_sync.sv
// Single-bit flop-chain synchroniser, async reset to 0.
// Ports: clk_i, rst_ni, d_i (async level), q_o (last stage).
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge detector: per-channel sync, edge FSM, pulse/sticky/counter.
// Ports: clock, reset_n (async low), bus (slave) carrying channel I/O and irq.
module edge_event_detector
    import edge_event_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    edge_event_detector_if.slave  bus
);

    localparam int FW = $clog2(SYNC_STAGES + 1);

    logic [FW-1:0]       fill_q, fill_d;
    logic                fill_done;
    logic [CHANNELS-1:0] pulse_v;
    logic [CHANNELS-1:0] sticky_v;
    logic                irq_q, irq_d;

    // Channel FSMs wait until the sync chains hold real samples.
    assign fill_done = (fill_q == FW'(SYNC_STAGES));
    assign fill_d    = fill_done ? fill_q : fill_q + FW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

        logic                 s;
        ch_state_e            state_q, state_d;
        logic                 rise, fall, det;
        logic [1:0]           mode_c;
        logic                 pulse_q;
        logic                 sticky_q, sticky_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

        edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (clock),
            .rst_ni (reset_n),
            .d_i    (bus.ain[i]),
            .q_o    (s)
        );

        assign mode_c = bus.mode[2*i +: 2];

        // First settled sample only seeds the state, so a level
        // held through reset never reports an edge.
        always_comb begin
            state_d = state_q;
            rise    = 1'b0;
            fall    = 1'b0;
            unique case (state_q)
                ST_UNINIT: begin
                    if (fill_done) state_d = s ? ST_HIGH : ST_LOW;
                end
                ST_LOW: begin
                    if (s) begin
                        state_d = ST_HIGH;
                        rise    = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        state_d = ST_LOW;
                        fall    = 1'b1;
                    end
                end
                default: state_d = ST_UNINIT;
            endcase
        end

        assign det = (rise && (mode_c == MODE_RISE || mode_c == MODE_BOTH))
                  || (fall && (mode_c == MODE_FALL || mode_c == MODE_BOTH));

        // A new event beats a simultaneous clear.
        always_comb begin
            sticky_d = sticky_q;
            cnt_d    = cnt_q;
            if (det) begin
                sticky_d = 1'b1;
            end else if (bus.clear[i]) begin
                sticky_d = 1'b0;
            end
            if (bus.clear[i]) begin
                cnt_d = det ? CNT_WIDTH'(1) : '0;
            end else if (det && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= ST_UNINIT;
                pulse_q  <= 1'b0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                state_q  <= state_d;
                pulse_q  <= det;
                sticky_q <= sticky_d;
                cnt_q    <= cnt_d;
            end
        end

        assign pulse_v[i]                        = pulse_q;
        assign sticky_v[i]                       = sticky_q;
        assign bus.count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;

    end

    // Registered from the sticky flags, so irq trails sticky by one cycle.
    assign irq_d = |(sticky_v & bus.irq_en);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.pulse  = pulse_v;
    assign bus.sticky = sticky_v;
    assign bus.irq    = irq_q;

endmodule
